parameter_cc_tx: RTL
====================

// Module: parameter_cc_tx
// PURPOSE
//  Transmit side of the synth parameter interface: turns PARAMETER::parameter_t updates back into MIDI
//  Control Change messages (status, controller, value) on a byte stream feeding the MIDI-out UART TX.
//  Sits beside the CC decoder that writes the parameter register: per-parameter change pulses and a
//  full-dump request queue messages; a serializer FSM emits them one byte per valid/ready transfer.
// PARAMETERS
//  CHANNEL      4'd0  MIDI channel placed in status nibble (status = 8'hB0 | CHANNEL)
// PORTS
//  clk          in   1     system clock
//  reset        in   1     synchronous, active-high reset
//  parameters   in   parameter_t  live parameter register (sampled at message start)
//  change       in   parameter_change_t  one-cycle change event; PARAM_NONE = no event
//  dump         in   1     one-cycle request: queue all seven parameters
//  tx_data      out  8     MIDI byte to UART TX
//  tx_valid     out  1     tx_data valid; held with stable data until accepted
//  tx_ready     in   1     UART TX can accept; transfer when tx_valid && tx_ready
//  busy         out  1     high while any message pending or in flight
// BEHAVIOUR
//  Reset: tx_valid=0, tx_data=8'h00, busy=0, pending mask=0, FSM=IDLE, value latch=0.
//  Pending mask: 7 bits, bit i-1 <-> parameter_change_t value i (VOLUME..DUTY_CYCLE).
//   change!=PARAM_NONE sets its bit; dump sets all; both in one cycle -> all set. Duplicates coalesce.
//   Bit clears when FSM selects it; a set in that same cycle wins (parameter re-sent later).
//  FSM: IDLE -> STATUS -> CTRL -> VALUE -> IDLE.
//   IDLE: if mask!=0, pick lowest set index (VOLUME highest priority), latch controller number and
//     field value[6:0] (bit7 forced 0), load tx_data=8'hB0|CHANNEL, tx_valid=1 -> STATUS.
//   STATUS/CTRL/VALUE: on transfer load next byte (controller, then value); after VALUE transfer
//     tx_valid=0 -> IDLE. One idle cycle between messages minimum.
//  Latency: change pulse in cycle N with FSM idle -> tx_valid high in cycle N+2 (status byte).
//  Value consistency: value latched in IDLE selection; later parameter edits do not alter the
//   message in flight (they arrive as new change events).
//  tx_ready low indefinitely: tx_valid/tx_data hold; events keep accumulating in mask (no loss).
//  tx_ready high while tx_valid low: ignored. busy = (mask!=0) || (FSM!=IDLE).
//  Reset mid-message: message abandoned, tx_valid drops next cycle; no partial resume.
// CONFIGURATION
//  MIDI_RUNNING_STATUS_EN defined: status byte omitted when equal to last status sent (IDLE goes
//   straight to CTRL loading controller byte); last-status register cleared by reset so first
//   message after reset always carries status. Messages are 2 bytes after the first.
//  Undefined: every message is 3 bytes; last-status register absent.
// STRUCTURE
//  PARAMETER package additions: CC_STATUS = 4'hB; function cc_number(parameter_change_t) returning
//   controller (VOLUME 7, UNISON_DETUNE 94, ATTACK 73, DECAY 75, SUSTAIN 70, RELEASE 72, DUTY 71);
//   function cc_value(parameter_t, parameter_change_t) selecting the field. Same map used by the
//   CC decoder so both ends agree.
//  Sub-module: cc_pending_arbiter (mask set/clear + lowest-index priority select); FSM in top.
// TESTING
//  Reset, change=PARAM_VOLUME, volume='h40, tx_ready=1 -> bytes B0,07,40; tx_valid first high N+2.
//  dump with DEFAULT_PARAMETERS -> 7 messages in order CC 7,94,73,75,70,72,71, values 40,00,00,00,7F,00,40.
//  tx_ready=0 for 50 cycles mid-CTRL -> tx_data=07 stable, tx_valid held; changes during stall coalesce.
//  change=PARAM_DECAY twice while VOLUME in flight, decay_time edited between -> one DECAY message,
//   value = latest at selection.
//  MIDI_RUNNING_STATUS_EN: two changes -> B0,07,v1,49,v2; reset between them -> status re-sent.
//  reset asserted during VALUE byte -> tx_valid=0 next cycle, busy=0, no further bytes.

Source files
------------

// File: rtl/parameter_cc_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parameter_cc_tx_pkg
// Description : Shared types and helpers for the synth parameter <-> MIDI CC
//               path: the live parameter register layout, the change-event
//               encoding, the controller-number map and the field selector.
//               The CC decoder uses the same map so both directions agree.
// Revision    : 1.0 - initial release
// ============================================================================
package parameter_cc_tx_pkg;

  localparam logic [3:0] CC_STATUS  = 4'hB;
  localparam int         NUM_PARAMS = 7;

  typedef struct packed {
    logic [7:0] volume;
    logic [7:0] unison_detune;
    logic [7:0] attack_time;
    logic [7:0] decay_time;
    logic [7:0] sustain_level;
    logic [7:0] release_time;
    logic [7:0] duty_cycle;
  } parameter_t;

  // Value i (1..7) maps onto pending-mask bit i-1; lower value = higher priority.
  typedef enum logic [2:0] {
    PARAM_NONE          = 3'd0,
    PARAM_VOLUME        = 3'd1,
    PARAM_UNISON_DETUNE = 3'd2,
    PARAM_ATTACK        = 3'd3,
    PARAM_DECAY         = 3'd4,
    PARAM_SUSTAIN       = 3'd5,
    PARAM_RELEASE       = 3'd6,
    PARAM_DUTY_CYCLE    = 3'd7
  } parameter_change_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATUS = 2'd1,
    ST_CTRL   = 2'd2,
    ST_VALUE  = 2'd3
  } tx_state_t;

  localparam parameter_t DEFAULT_PARAMETERS = '{
    volume:        8'h40,
    unison_detune: 8'h00,
    attack_time:   8'h00,
    decay_time:    8'h00,
    sustain_level: 8'h7F,
    release_time:  8'h00,
    duty_cycle:    8'h40
  };

  function automatic logic [7:0] cc_number(input parameter_change_t sel);
    case (sel)
      PARAM_VOLUME:        cc_number = 8'd7;
      PARAM_UNISON_DETUNE: cc_number = 8'd94;
      PARAM_ATTACK:        cc_number = 8'd73;
      PARAM_DECAY:         cc_number = 8'd75;
      PARAM_SUSTAIN:       cc_number = 8'd70;
      PARAM_RELEASE:       cc_number = 8'd72;
      PARAM_DUTY_CYCLE:    cc_number = 8'd71;
      default:             cc_number = 8'd0;
    endcase
  endfunction

  // Full 8-bit field; the transmitter clears bit 7 before it goes on the wire.
  function automatic logic [7:0] cc_value(input parameter_t p, input parameter_change_t sel);
    case (sel)
      PARAM_VOLUME:        cc_value = p.volume;
      PARAM_UNISON_DETUNE: cc_value = p.unison_detune;
      PARAM_ATTACK:        cc_value = p.attack_time;
      PARAM_DECAY:         cc_value = p.decay_time;
      PARAM_SUSTAIN:       cc_value = p.sustain_level;
      PARAM_RELEASE:       cc_value = p.release_time;
      PARAM_DUTY_CYCLE:    cc_value = p.duty_cycle;
      default:             cc_value = 8'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/parameter_cc_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : parameter_cc_tx_if
// Description : Byte-stream valid/ready link from the CC transmitter to the
//               MIDI-out UART TX.
//               tx_data  - MIDI byte (master -> slave)
//               tx_valid - byte valid, held stable until accepted
//               tx_ready - slave can accept; transfer on valid && ready
// Revision    : 1.0 - initial release
// ============================================================================
interface parameter_cc_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/parameter_cc_tx_cc_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cc_pending_arbiter
// Description : Seven-bit pending mask of parameters awaiting transmission,
//               with lowest-index priority selection.
//   clk, reset - clock, synchronous active-high reset
//   change     - one-cycle change event (PARAM_NONE = none)
//   dump       - one-cycle request to mark every parameter pending
//   take       - consumer takes the current selection this cycle
//   pending    - at least one parameter pending
//   sel        - highest-priority pending parameter (valid when pending)
// Revision    : 1.0 - initial release
// ============================================================================
module cc_pending_arbiter
  import parameter_cc_tx_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              reset,
  input  parameter_change_t      change,
  input  wire logic              dump,
  input  wire logic              take,
  output logic                   pending,
  output parameter_change_t      sel
);

  logic [NUM_PARAMS-1:0] r_mask;
  logic [NUM_PARAMS-1:0] w_set;
  logic [NUM_PARAMS-1:0] w_lowest;
  logic [NUM_PARAMS-1:0] w_clear;

  always_comb begin
    w_set = '0;
    if (dump) begin
      w_set = '1;
    end
    if (change != PARAM_NONE) begin
      w_set[3'(change) - 3'd1] = 1'b1;
    end
  end

  // Isolate the lowest set bit as a one-hot clear vector.
  assign w_lowest = r_mask & (~r_mask + 7'd1);
  assign w_clear  = take ? w_lowest : '0;
  assign pending  = |r_mask;

  always_comb begin
    sel = PARAM_NONE;
    for (int i = NUM_PARAMS - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        sel = parameter_change_t'(3'(i + 1));
      end
    end
  end

  // Sets are applied after the clear so a re-trigger in the selection cycle
  // keeps the parameter pending for another message.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else begin
      r_mask <= (r_mask & ~w_clear) | w_set;
    end
  end

endmodule
`default_nettype wire

// File: rtl/parameter_cc_tx.sv
`default_nettype none
// ============================================================================
// Module      : parameter_cc_tx
// Description : Converts parameter change events into MIDI Control Change
//               messages (status, controller, value) on a valid/ready byte
//               stream for the MIDI-out UART.
//   clk, reset - clock, synchronous active-high reset
//   parameters - live parameter register, sampled when a message is chosen
//   change     - one-cycle change event (PARAM_NONE = none)
//   dump       - one-cycle request to queue all seven parameters
//   tx         - byte stream (tx_data / tx_valid / tx_ready), master side
//   busy       - a message is pending or in flight
// Build option: MIDI_RUNNING_STATUS_EN - omit the status byte when it equals
//   the last status byte sent (cleared by reset).
// Revision    : 1.0 - initial release
// ============================================================================
module parameter_cc_tx
  import parameter_cc_tx_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
)(
  input  wire logic              clk,
  input  wire logic              reset,
  input  parameter_t             parameters,
  input  parameter_change_t      change,
  input  wire logic              dump,
  parameter_cc_tx_if.master      tx,
  output logic                   busy
);

  localparam logic [7:0] C_STATUS_BYTE = {CC_STATUS, CHANNEL};

  tx_state_t         r_state, w_state;
  logic [7:0]        r_tx_data, w_tx_data;
  logic              r_tx_valid, w_tx_valid;
  logic [7:0]        r_ctrl, w_ctrl;
  logic [7:0]        r_value, w_value;
  logic              w_take;
  logic              w_xfer;
  logic              w_pending;
  parameter_change_t w_sel;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]        r_last_status, w_last_status;
`endif

  cc_pending_arbiter u_arbiter (
    .clk     (clk),
    .reset   (reset),
    .change  (change),
    .dump    (dump),
    .take    (w_take),
    .pending (w_pending),
    .sel     (w_sel)
  );

  assign w_xfer      = r_tx_valid && tx.tx_ready;
  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign busy        = w_pending || (r_state != ST_IDLE);

  always_comb begin
    w_state    = r_state;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_ctrl     = r_ctrl;
    w_value    = r_value;
    w_take     = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    w_last_status = r_last_status;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          // Value captured here; later edits arrive as their own change events.
          w_take     = 1'b1;
          w_ctrl     = cc_number(w_sel);
          w_value    = cc_value(parameters, w_sel) & 8'h7F;
          w_tx_valid = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
          if (r_last_status == C_STATUS_BYTE) begin
            w_tx_data = w_ctrl;
            w_state   = ST_CTRL;
          end else begin
            w_tx_data = C_STATUS_BYTE;
            w_state   = ST_STATUS;
          end
`else
          w_tx_data = C_STATUS_BYTE;
          w_state   = ST_STATUS;
`endif
        end
      end
      ST_STATUS: begin
        if (w_xfer) begin
`ifdef MIDI_RUNNING_STATUS_EN
          w_last_status = r_tx_data;
`endif
          w_tx_data = r_ctrl;
          w_state   = ST_CTRL;
        end
      end
      ST_CTRL: begin
        if (w_xfer) begin
          w_tx_data = r_value;
          w_state   = ST_VALUE;
        end
      end
      ST_VALUE: begin
        // Returning to IDLE guarantees one dead cycle between messages.
        if (w_xfer) begin
          w_tx_valid = 1'b0;
          w_state    = ST_IDLE;
        end
      end
      default: begin
        w_tx_valid = 1'b0;
        w_state    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_ctrl     <= 8'h00;
      r_value    <= 8'h00;
`ifdef MIDI_RUNNING_STATUS_EN
      r_last_status <= 8'h00;
`endif
    end else begin
      r_state    <= w_state;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_ctrl     <= w_ctrl;
      r_value    <= w_value;
`ifdef MIDI_RUNNING_STATUS_EN
      r_last_status <= w_last_status;
`endif
    end
  end

endmodule
`default_nettype wire
